// File: rtl/lc3_pkg.sv
// LC-3 memory-access sequencer shared definitions.
// Opcodes, FSM state encoding and address mux select codes.
package lc3_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;

  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_BASE  = 1'b1;
  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD,
    S_RD2,
    S_WR,
    S_WB
  } state_e;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Condition-code generator: 16-bit value to {neg,zero,pos}.
module lc3_nzp_gen (
  input  logic [15:0] data,
  output logic [2:0]  nzp
);

  always_comb begin
    nzp = 3'b001;
    unique case (1'b1)
      data[15]:         nzp = 3'b100;
      (data == 16'h0):  nzp = 3'b010;
      default:          nzp = 3'b001;
    endcase
  end

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 LD/LDI/LDR/LEA/ST/STI/STR sequencer with MAR/MDR and memory handshake.
// Optional per-access wait timeout enabled by LC3_MEM_TIMEOUT_EN.
module lc3_mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [15:0] addr_in,
  input  logic [15:0] sr_data,
  output logic        addr1_mux,
  output logic [1:0]  addr2_mux,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        reg_we,
  output logic [2:0]  dr,
  output logic [15:0] reg_wdata,
  output logic [2:0]  nzp,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [15:0]   ir_q, ir_d;
  logic [15:0]   mar_q, mar_d;
  logic [15:0]   mdr_q, mdr_d;
  logic [2:0]    nzp_q, nzp_d;
  logic [2:0]    nzp_new;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op;
  logic [15:0]   wb_val;
  logic          tmo;

  assign op     = ir_q[15:12];
  assign wb_val = (op == OP_LEA) ? mar_q : mdr_q;

`ifdef LC3_MEM_TIMEOUT_EN
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  lc3_nzp_gen u_nzp (
    .data (wb_val),
    .nzp  (nzp_new)
  );

  assign mem_addr = mar_q;
  assign dr       = ir_q[11:9];
  assign nzp      = nzp_q;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    nzp_d     = nzp_q;
    cnt_d     = cnt_q;
    addr1_mux = ADDR1_PC;
    addr2_mux = ADDR2_ZERO;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 16'h0;
    reg_we    = 1'b0;
    reg_wdata = 16'h0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_d    = ir;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        mar_d = addr_in;
        cnt_d = '0;
        unique case (op)
          OP_LEA: begin
            addr2_mux = ADDR2_OFF9;
            state_d   = S_WB;
          end
          OP_LD, OP_LDI, OP_STI: begin
            addr2_mux = ADDR2_OFF9;
            state_d   = S_RD;
          end
          OP_ST: begin
            addr2_mux = ADDR2_OFF9;
            state_d   = S_WR;
          end
          OP_LDR: begin
            addr1_mux = ADDR1_BASE;
            addr2_mux = ADDR2_OFF6;
            state_d   = S_RD;
          end
          OP_STR: begin
            addr1_mux = ADDR1_BASE;
            addr2_mux = ADDR2_OFF6;
            state_d   = S_WR;
          end
          default: begin
            err     = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_RD, S_RD2: begin
        mem_en = 1'b1;
        if (tmo) begin
          mem_en  = 1'b0;
          err     = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (mem_ready) begin
          cnt_d = '0;
          mdr_d = mem_rdata;
          // First read of an indirect op fetches the pointer
          if (state_q == S_RD && op == OP_LDI) begin
            mar_d   = mem_rdata;
            state_d = S_RD2;
          end else if (state_q == S_RD && op == OP_STI) begin
            mar_d   = mem_rdata;
            state_d = S_WR;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = sr_data;
        if (tmo) begin
          mem_en  = 1'b0;
          mem_we  = 1'b0;
          err     = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (mem_ready) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        reg_wdata = wb_val;
        nzp_d     = nzp_new;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0;
      mar_q   <= 16'h0;
      mdr_q   <= 16'h0;
      nzp_q   <= 3'b010;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      nzp_q   <= nzp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
